mem_stage: RTL and testbench

Memory-access pipeline stage sitting directly after EX. It consumes EX's result, destination-register enable and address, plus a memory-op code and store data. For loads and stores it runs a req/ack transaction on the data-RAM port, stalls the pipeline until the access completes, aligns or sign-extends load data, and registers the write-back triple toward WB. Non-memory instructions pass through in one cycle.

---
 rtl/mem_stage.sv | 197 +++++++++++++++++++
 tb/tb_mem_stage.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage between EX and WB.
// Runs a req/ack data-RAM access for loads/stores, aligns load data.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   result_in                 EX result / effective address
//   write_reg_en_in           EX register-write enable
//   write_reg_addr_in         EX destination register
//   mem_op                    memory-op code (NONE/LB/LBU/LH/LHU/LW/SB/SH/SW)
//   store_data                store value (rt)
//   stall_req                 combinational hold request to upstream
//   ram_en/we/sel/addr/wdata  registered data-RAM request
//   ram_rdata, ram_ack        RAM read data and completion pulse
//   result_out, write_reg_*   registered write-back triple toward WB
//   excp_adel, excp_ades      one-cycle misaligned load/store pulses
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] result_in,
    input  logic        write_reg_en_in,
    input  logic [4:0]  write_reg_addr_in,
    input  logic [3:0]  mem_op,
    input  logic [31:0] store_data,
    output logic        stall_req,
    output logic        ram_en,
    output logic        ram_we,
    output logic [3:0]  ram_sel,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    input  logic        ram_ack,
    output logic [31:0] result_out,
    output logic        write_reg_en_out,
    output logic [4:0]  write_reg_addr_out,
    output logic        excp_adel,
    output logic        excp_ades
);

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd8;
    localparam logic [3:0] OP_SH  = 4'd9;
    localparam logic [3:0] OP_SW  = 4'd10;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t state, state_n;

    logic [1:0]  a;
    logic        is_load, is_store, misal;
    logic [3:0]  sel_c;
    logic [31:0] wdata_c, load_c;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    logic        ram_en_n, ram_we_n;
    logic [3:0]  ram_sel_n;
    logic [31:0] ram_addr_n, ram_wdata_n, result_n;
    logic        wen_n, adel_n, ades_n;
    logic [4:0]  waddr_n;

    assign a = result_in[1:0];

    // Decode op class, alignment, lane selects and load alignment.
    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        misal    = 1'b0;
        sel_c    = 4'hF;
        wdata_c  = store_data;
        ld_byte  = ram_rdata[{a, 3'b000} +: 8];
        ld_half  = a[1] ? ram_rdata[31:16] : ram_rdata[15:0];
        load_c   = ram_rdata;
        unique case (mem_op)
            OP_LB: begin
                is_load = 1'b1;
                load_c  = {{24{ld_byte[7]}}, ld_byte};
            end
            OP_LBU: begin
                is_load = 1'b1;
                load_c  = {24'd0, ld_byte};
            end
            OP_LH: begin
                is_load = 1'b1;
                misal   = a[0];
                load_c  = {{16{ld_half[15]}}, ld_half};
            end
            OP_LHU: begin
                is_load = 1'b1;
                misal   = a[0];
                load_c  = {16'd0, ld_half};
            end
            OP_LW: begin
                is_load = 1'b1;
                misal   = (a != 2'd0);
            end
            OP_SB: begin
                is_store = 1'b1;
                sel_c    = 4'b0001 << a;
                wdata_c  = {4{store_data[7:0]}};
            end
            OP_SH: begin
                is_store = 1'b1;
                misal    = a[0];
                sel_c    = 4'b0011 << a;
                wdata_c  = {2{store_data[15:0]}};
            end
            OP_SW: begin
                is_store = 1'b1;
                misal    = (a != 2'd0);
            end
            default: ;
        endcase
    end

    // Next-state and next registered outputs; WB defaults to a bubble.
    always_comb begin
        state_n     = state;
        stall_req   = 1'b0;
        ram_en_n    = 1'b0;
        ram_we_n    = ram_we;
        ram_sel_n   = ram_sel;
        ram_addr_n  = ram_addr;
        ram_wdata_n = ram_wdata;
        result_n    = 32'd0;
        wen_n       = 1'b0;
        waddr_n     = 5'd0;
        adel_n      = 1'b0;
        ades_n      = 1'b0;
        unique case (state)
            IDLE: begin
                if ((is_load || is_store) && !misal) begin
                    stall_req   = 1'b1;
                    state_n     = BUSY;
                    ram_en_n    = 1'b1;
                    ram_we_n    = is_store;
                    ram_sel_n   = sel_c;
                    ram_addr_n  = {result_in[31:2], 2'b00};
                    ram_wdata_n = wdata_c;
                end else if (is_load || is_store) begin
                    adel_n = is_load;
                    ades_n = is_store;
                end else begin
                    result_n = result_in;
                    wen_n    = write_reg_en_in;
                    waddr_n  = write_reg_addr_in;
                end
            end
            BUSY: begin
                stall_req = !ram_ack;
                ram_en_n  = 1'b1;
                if (ram_ack) begin
                    state_n  = IDLE;
                    ram_en_n = 1'b0;
                    if (is_load) begin
                        result_n = load_c;
                        wen_n    = write_reg_en_in;
                        waddr_n  = write_reg_addr_in;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            ram_en             <= 1'b0;
            ram_we             <= 1'b0;
            ram_sel            <= 4'd0;
            ram_addr           <= 32'd0;
            ram_wdata          <= 32'd0;
            result_out         <= 32'd0;
            write_reg_en_out   <= 1'b0;
            write_reg_addr_out <= 5'd0;
            excp_adel          <= 1'b0;
            excp_ades          <= 1'b0;
        end else begin
            state              <= state_n;
            ram_en             <= ram_en_n;
            ram_we             <= ram_we_n;
            ram_sel            <= ram_sel_n;
            ram_addr           <= ram_addr_n;
            ram_wdata          <= ram_wdata_n;
            result_out         <= result_n;
            write_reg_en_out   <= wen_n;
            write_reg_addr_out <= waddr_n;
            excp_adel          <= adel_n;
            excp_ades          <= ades_n;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed-vector bench for mem_stage.
// Expected values are hand-computed constants.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] result_in;
    logic        write_reg_en_in;
    logic [4:0]  write_reg_addr_in;
    logic [3:0]  mem_op;
    logic [31:0] store_data;
    logic        stall_req;
    logic        ram_en, ram_we;
    logic [3:0]  ram_sel;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;
    logic        ram_ack;
    logic [31:0] result_out;
    logic        write_reg_en_out;
    logic [4:0]  write_reg_addr_out;
    logic        excp_adel, excp_ades;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk                (clk),
        .rst                (rst),
        .result_in          (result_in),
        .write_reg_en_in    (write_reg_en_in),
        .write_reg_addr_in  (write_reg_addr_in),
        .mem_op             (mem_op),
        .store_data         (store_data),
        .stall_req          (stall_req),
        .ram_en             (ram_en),
        .ram_we             (ram_we),
        .ram_sel            (ram_sel),
        .ram_addr           (ram_addr),
        .ram_wdata          (ram_wdata),
        .ram_rdata          (ram_rdata),
        .ram_ack            (ram_ack),
        .result_out         (result_out),
        .write_reg_en_out   (write_reg_en_out),
        .write_reg_addr_out (write_reg_addr_out),
        .excp_adel          (excp_adel),
        .excp_ades          (excp_ades)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] r, input logic en,
                         input logic [4:0] ad, input logic [3:0] op,
                         input logic [31:0] sd);
        result_in         = r;
        write_reg_en_in   = en;
        write_reg_addr_in = ad;
        mem_op            = op;
        store_data        = sd;
        #1;
    endtask

    task automatic check_wb(input string tag, input logic [31:0] r,
                            input logic en, input logic [4:0] ad);
        check({tag, ".res"}, result_out, r);
        check({tag, ".en"}, {31'd0, write_reg_en_out}, {31'd0, en});
        check({tag, ".addr"}, {27'd0, write_reg_addr_out}, {27'd0, ad});
    endtask

    // One load with ack in the first BUSY cycle; checks the WB result.
    task automatic do_load(input string tag, input logic [31:0] ad,
                           input logic [3:0] op, input logic [31:0] rd,
                           input logic [31:0] exp);
        drive(ad, 1'b1, 5'd9, op, 32'd0);
        check({tag, ".stall0"}, {31'd0, stall_req}, 32'd1);
        tick();
        check({tag, ".ram_en"}, {31'd0, ram_en}, 32'd1);
        ram_rdata = rd;
        ram_ack   = 1'b1;
        #1;
        check({tag, ".stall1"}, {31'd0, stall_req}, 32'd0);
        tick();
        ram_ack = 1'b0;
        check_wb(tag, exp, 1'b1, 5'd9);
        check({tag, ".ram_en_off"}, {31'd0, ram_en}, 32'd0);
        drive(32'd0, 1'b0, 5'd0, 4'd0, 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        ram_ack   = 1'b0;
        ram_rdata = 32'd0;
        drive(32'd0, 1'b0, 5'd0, 4'd0, 32'd0);
        tick();
        tick();
        check_wb("rst", 32'd0, 1'b0, 5'd0);
        check("rst.ram_en", {31'd0, ram_en}, 32'd0);
        check("rst.ram_sel", {28'd0, ram_sel}, 32'd0);
        rst = 1'b0;

        // Pass-through
        drive(32'h1234_5678, 1'b1, 5'd5, 4'd0, 32'd0);
        check("pt.stall", {31'd0, stall_req}, 32'd0);
        tick();
        check_wb("pt", 32'h1234_5678, 1'b1, 5'd5);

        // LB sign-extend
        drive(32'h0000_1003, 1'b1, 5'd7, 4'd1, 32'd0);
        check("lb.stall0", {31'd0, stall_req}, 32'd1);
        tick();
        check("lb.ram_en", {31'd0, ram_en}, 32'd1);
        check("lb.ram_we", {31'd0, ram_we}, 32'd0);
        check("lb.ram_sel", {28'd0, ram_sel}, 32'hF);
        check("lb.ram_addr", ram_addr, 32'h0000_1000);
        check("lb.bubble", {31'd0, write_reg_en_out}, 32'd0);
        ram_rdata = 32'h80FF_FFFF;
        ram_ack   = 1'b1;
        #1;
        check("lb.stall1", {31'd0, stall_req}, 32'd0);
        tick();
        ram_ack = 1'b0;
        check_wb("lb", 32'hFFFF_FF80, 1'b1, 5'd7);
        check("lb.ram_en_off", {31'd0, ram_en}, 32'd0);

        // SH, ack in the 3rd BUSY cycle
        drive(32'h0000_2002, 1'b0, 5'd0, 4'd9, 32'hAAAA_BEEF);
        check("sh.stall0", {31'd0, stall_req}, 32'd1);
        for (int i = 1; i <= 3; i++) begin
            tick();
            if (i == 3) begin
                ram_ack = 1'b1;
                #1;
            end
            check($sformatf("sh.en%0d", i), {31'd0, ram_en}, 32'd1);
            check($sformatf("sh.we%0d", i), {31'd0, ram_we}, 32'd1);
            check($sformatf("sh.sel%0d", i), {28'd0, ram_sel}, 32'hC);
            check($sformatf("sh.wd%0d", i), ram_wdata, 32'hBEEF_BEEF);
            check($sformatf("sh.addr%0d", i), ram_addr, 32'h0000_2000);
            check($sformatf("sh.stall%0d", i), {31'd0, stall_req},
                  (i == 3) ? 32'd0 : 32'd1);
            check($sformatf("sh.wen%0d", i),
                  {31'd0, write_reg_en_out}, 32'd0);
        end
        tick();
        ram_ack = 1'b0;
        check("sh.ram_en_off", {31'd0, ram_en}, 32'd0);
        check("sh.wen", {31'd0, write_reg_en_out}, 32'd0);

        // SB lane 1
        drive(32'h0000_0041, 1'b0, 5'd0, 4'd8, 32'h1234_5678);
        tick();
        check("sb.sel", {28'd0, ram_sel}, 32'h2);
        check("sb.wd", ram_wdata, 32'h7878_7878);
        ram_ack = 1'b1;
        tick();
        ram_ack = 1'b0;

        // LW misaligned
        drive(32'h0000_3001, 1'b1, 5'd3, 4'd5, 32'd0);
        check("adel.stall", {31'd0, stall_req}, 32'd0);
        tick();
        check("adel.ram_en", {31'd0, ram_en}, 32'd0);
        check("adel.pulse", {31'd0, excp_adel}, 32'd1);
        check("adel.ades", {31'd0, excp_ades}, 32'd0);
        check("adel.wen", {31'd0, write_reg_en_out}, 32'd0);
        drive(32'd0, 1'b0, 5'd0, 4'd0, 32'd0);
        tick();
        check("adel.end", {31'd0, excp_adel}, 32'd0);

        // SW misaligned
        drive(32'h0000_3002, 1'b0, 5'd0, 4'd10, 32'h1);
        tick();
        check("ades.pulse", {31'd0, excp_ades}, 32'd1);
        check("ades.ram_en", {31'd0, ram_en}, 32'd0);
        drive(32'd0, 1'b0, 5'd0, 4'd0, 32'd0);
        tick();
        check("ades.end", {31'd0, excp_ades}, 32'd0);

        // Load alignment variants
        do_load("lhu", 32'h0000_0002, 4'd4, 32'h9ABC_0000, 32'h0000_9ABC);
        do_load("lh", 32'h0000_0000, 4'd3, 32'h0000_8001, 32'hFFFF_8001);
        do_load("lbu", 32'h0000_0001, 4'd2, 32'h0000_F000, 32'h0000_00F0);
        do_load("lw", 32'h0000_0010, 4'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

        // Ack in IDLE ignored
        drive(32'h0000_00AB, 1'b1, 5'd2, 4'd0, 32'd0);
        ram_ack = 1'b1;
        tick();
        ram_ack = 1'b0;
        check("idle_ack.ram_en", {31'd0, ram_en}, 32'd0);
        check_wb("idle_ack", 32'h0000_00AB, 1'b1, 5'd2);

        // Reset mid-BUSY, late ack
        drive(32'h0000_4000, 1'b1, 5'd4, 4'd5, 32'd0);
        tick();
        check("rb.ram_en", {31'd0, ram_en}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rb.ram_en0", {31'd0, ram_en}, 32'd0);
        check("rb.ram_addr", ram_addr, 32'd0);
        check_wb("rb", 32'd0, 1'b0, 5'd0);
        drive(32'h0000_0055, 1'b1, 5'd6, 4'd0, 32'd0);
        ram_ack   = 1'b1;
        ram_rdata = 32'hFFFF_FFFF;
        #1;
        check("rb.stall", {31'd0, stall_req}, 32'd0);
        tick();
        ram_ack = 1'b0;
        check("rb.late_en", {31'd0, ram_en}, 32'd0);
        check_wb("rb.pt", 32'h0000_0055, 1'b1, 5'd6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
